// File: rtl/uart_pkg.sv
// uart_pkg: register map, field indices, parity modes and FSM
// encodings shared by the Wishbone UART and its FIFOs.
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    localparam logic [2:0] ADDR_TXDATA = 3'd0;
    localparam logic [2:0] ADDR_RXDATA = 3'd1;
    localparam logic [2:0] ADDR_DIV_LO = 3'd2;
    localparam logic [2:0] ADDR_DIV_HI = 3'd3;
    localparam logic [2:0] ADDR_CTRL   = 3'd4;
    localparam logic [2:0] ADDR_STATUS = 3'd5;

    localparam int CTRL_STOP2  = 4;
    localparam int CTRL_RX_EN  = 5;
    localparam int CTRL_TX_EN  = 6;
    localparam int CTRL_IRQ_EN = 7;

    localparam int ST_TX_EMPTY = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_RX_EMPTY = 2;
    localparam int ST_RX_FULL  = 3;
    localparam int ST_PAR_ERR  = 4;

    localparam logic [7:0] CTRL_RESET = 8'h63;

    localparam logic [1:0] PAR_NONE  = 2'b00;
    localparam logic [1:0] PAR_EVEN  = 2'b01;
    localparam logic [1:0] PAR_ODD   = 2'b10;
    localparam logic [1:0] PAR_NONE2 = 2'b11;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_t;

    typedef struct packed {
        logic [2:0] last_bit;
        logic [1:0] parity;
        logic       stop2;
    } frame_cfg_t;

    function automatic frame_cfg_t decode_cfg(input logic [7:0] ctrl);
        frame_cfg_t c;
        c.last_bit = 3'd4 + {1'b0, ctrl[1:0]};
        c.parity   = ctrl[3:2];
        c.stop2    = ctrl[CTRL_STOP2];
        return c;
    endfunction

    function automatic logic has_parity(input logic [1:0] p);
        return (p == PAR_EVEN) || (p == PAR_ODD);
    endfunction

    // x is the XOR of the data bits; odd parity inverts it
    function automatic logic par_bit(input logic [1:0] p, input logic x);
        return (p == PAR_ODD) ? ~x : x;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous first-word-fall-through FIFO; push and pop
// in the same cycle always both happen, leaving occupancy unchanged.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         data_in,
    output logic [WIDTH-1:0]         data_out,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & (~full | pop);
    assign do_pop   = pop & (~empty | push);
    assign data_out = empty ? data_in : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/uart_core.sv
// uart_core: Wishbone UART with programmable framing, 16x oversampled
// receiver, TX/RX FIFOs, sticky error flags and a level interrupt.
module uart_core
    import uart_pkg::*;
#(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd77
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       tx_bit,
    input  logic       rx_bit,
    input  logic [2:0] wb_addr,
    input  logic [7:0] wb_data_in,
    output logic [7:0] wb_data_out,
    input  logic       wb_we,
    input  logic       wb_stb,
    output logic       wb_ack,
    output logic       irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]  ctrl;
    logic [15:0] div;
    logic [15:0] div_cnt;
    logic        tick;
    logic [3:0]  sticky;
    logic [7:0]  status;
    logic [7:0]  rdata;
    logic        access, wr, rd, div_wr;

    logic          tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]    tx_dout;
    logic [CW-1:0] tx_count;
    logic          rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]    rx_dout;
    logic [CW-1:0] rx_count;
    logic          perr_set, ferr_set, rx_ovr_set, tx_ovr_set;

    assign access = wb_stb & ~wb_ack;
    assign wr     = access & wb_we;
    assign rd     = access & ~wb_we;
    assign div_wr = wr & ((wb_addr == ADDR_DIV_LO) | (wb_addr == ADDR_DIV_HI));

    assign tx_push    = wr & (wb_addr == ADDR_TXDATA);
    assign rx_pop     = rd & (wb_addr == ADDR_RXDATA) & ~rx_empty;
    assign tx_ovr_set = tx_push & tx_full & ~tx_pop;
    assign rx_ovr_set = rx_push & rx_full & ~rx_pop;

    assign status = {sticky,
                     rx_count == CW'(FIFO_DEPTH), rx_count == '0,
                     tx_count == CW'(FIFO_DEPTH), tx_count == '0};

    assign irq = ctrl[CTRL_IRQ_EN] & (~rx_empty | tx_empty | (|sticky));

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .reset_n(reset_n),
        .push(tx_push), .pop(tx_pop), .data_in(wb_data_in),
        .data_out(tx_dout), .full(tx_full), .empty(tx_empty),
        .count(tx_count)
    );

    logic [7:0] rx_data;

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .reset_n(reset_n),
        .push(rx_push), .pop(rx_pop), .data_in(rx_data),
        .data_out(rx_dout), .full(rx_full), .empty(rx_empty),
        .count(rx_count)
    );

    always_comb begin
        rdata = '0;
        case (wb_addr)
            ADDR_RXDATA: rdata = rx_empty ? 8'h00 : rx_dout;
            ADDR_DIV_LO: rdata = div[7:0];
            ADDR_DIV_HI: rdata = div[15:8];
            ADDR_CTRL:   rdata = ctrl;
            ADDR_STATUS: rdata = status;
            default:     rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_ack      <= 1'b0;
            wb_data_out <= '0;
            ctrl        <= CTRL_RESET;
            div         <= DIV_RESET;
            sticky      <= '0;
        end else begin
            wb_ack <= access;
            if (rd) wb_data_out <= rdata;
            if (wr && wb_addr == ADDR_DIV_LO) div[7:0]  <= wb_data_in;
            if (wr && wb_addr == ADDR_DIV_HI) div[15:8] <= wb_data_in;
            if (wr && wb_addr == ADDR_CTRL)   ctrl      <= wb_data_in;
            // new error events win over a same-cycle clear
            sticky <= (sticky & ~((wr && wb_addr == ADDR_STATUS) ?
                                  wb_data_in[7:4] : 4'h0))
                    | {tx_ovr_set, rx_ovr_set, ferr_set, perr_set};
        end
    end

    assign tick = (div_cnt == div);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)           div_cnt <= '0;
        else if (div_wr || tick) div_cnt <= '0;
        else                    div_cnt <= div_cnt + 16'd1;
    end

    logic rx_s1, rx_s2, rx_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= rx_bit;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    tx_state_t  tx_state, tx_state_n;
    logic [3:0] tx_cnt, tx_cnt_n;
    logic [2:0] tx_idx, tx_idx_n;
    logic [7:0] tx_shift, tx_shift_n;
    logic       tx_par, tx_par_n, tx_line_n, tx_end;
    frame_cfg_t tx_cfg, tx_cfg_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx_cfg   <= '0;
            tx_bit   <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_idx   <= tx_idx_n;
            tx_shift <= tx_shift_n;
            tx_par   <= tx_par_n;
            tx_cfg   <= tx_cfg_n;
            tx_bit   <= tx_line_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_idx_n   = tx_idx;
        tx_shift_n = tx_shift;
        tx_par_n   = tx_par;
        tx_cfg_n   = tx_cfg;
        tx_line_n  = tx_bit;
        tx_pop     = 1'b0;
        tx_end     = tick && (tx_cnt == 4'(OVERSAMPLE - 1));
        if (tick && tx_state != TX_IDLE) tx_cnt_n = tx_cnt + 4'd1;
        unique case (tx_state)
            TX_IDLE: begin
                tx_line_n = 1'b1;
                // frames start on a tick so every cell is exactly 16 ticks
                if (tick && !tx_empty && ctrl[CTRL_TX_EN]) begin
                    tx_pop     = 1'b1;
                    tx_cfg_n   = decode_cfg(ctrl);
                    tx_shift_n = tx_dout;
                    tx_par_n   = 1'b0;
                    tx_cnt_n   = '0;
                    tx_state_n = TX_START;
                    tx_line_n  = 1'b0;
                end
            end
            TX_START: if (tx_end) begin
                tx_idx_n   = '0;
                tx_state_n = TX_DATA;
                tx_line_n  = tx_shift[0];
            end
            TX_DATA: if (tx_end) begin
                tx_par_n   = tx_par ^ tx_shift[0];
                tx_shift_n = tx_shift >> 1;
                if (tx_idx != tx_cfg.last_bit) begin
                    tx_idx_n  = tx_idx + 3'd1;
                    tx_line_n = tx_shift[1];
                end else if (has_parity(tx_cfg.parity)) begin
                    tx_state_n = TX_PARITY;
                    tx_line_n  = par_bit(tx_cfg.parity, tx_par ^ tx_shift[0]);
                end else begin
                    tx_state_n = TX_STOP;
                    tx_idx_n   = '0;
                    tx_line_n  = 1'b1;
                end
            end
            TX_PARITY: if (tx_end) begin
                tx_state_n = TX_STOP;
                tx_idx_n   = '0;
                tx_line_n  = 1'b1;
            end
            TX_STOP: if (tx_end) begin
                tx_line_n = 1'b1;
                if (tx_cfg.stop2 && tx_idx == 3'd0) tx_idx_n = 3'd1;
                else                                tx_state_n = TX_IDLE;
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    rx_state_t  rx_state, rx_state_n;
    logic [3:0] rx_cnt, rx_cnt_n;
    logic [2:0] rx_idx, rx_idx_n, rx_last, rx_last_n;
    logic [1:0] rx_pmode, rx_pmode_n;
    logic [7:0] rx_data_n;
    logic       rx_par, rx_par_n, rx_smp, rx_end;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_last  <= '0;
            rx_pmode <= PAR_NONE;
            rx_data  <= '0;
            rx_par   <= 1'b0;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_idx   <= rx_idx_n;
            rx_last  <= rx_last_n;
            rx_pmode <= rx_pmode_n;
            rx_data  <= rx_data_n;
            rx_par   <= rx_par_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_idx_n   = rx_idx;
        rx_last_n  = rx_last;
        rx_pmode_n = rx_pmode;
        rx_data_n  = rx_data;
        rx_par_n   = rx_par;
        rx_push    = 1'b0;
        perr_set   = 1'b0;
        ferr_set   = 1'b0;
        rx_smp     = tick && (rx_cnt == 4'(OVERSAMPLE / 2 - 1));
        rx_end     = tick && (rx_cnt == 4'(OVERSAMPLE - 1));
        if (tick && rx_state != RX_IDLE) rx_cnt_n = rx_cnt + 4'd1;
        unique case (rx_state)
            RX_IDLE: if (ctrl[CTRL_RX_EN] && rx_d && !rx_s2) begin
                rx_state_n = RX_START;
                rx_cnt_n   = '0;
                rx_last_n  = decode_cfg(ctrl).last_bit;
                rx_pmode_n = ctrl[3:2];
                rx_data_n  = '0;
                rx_par_n   = 1'b0;
            end
            RX_START: begin
                if (rx_smp && rx_s2) rx_state_n = RX_IDLE;
                else if (rx_end) begin
                    rx_state_n = RX_DATA;
                    rx_idx_n   = '0;
                end
            end
            RX_DATA: begin
                if (rx_smp) begin
                    rx_data_n[rx_idx] = rx_s2;
                    rx_par_n          = rx_par ^ rx_s2;
                end
                if (rx_end) begin
                    if (rx_idx != rx_last)        rx_idx_n   = rx_idx + 3'd1;
                    else if (has_parity(rx_pmode)) rx_state_n = RX_PARITY;
                    else                          rx_state_n = RX_STOP;
                end
            end
            RX_PARITY: begin
                if (rx_smp && rx_s2 != par_bit(rx_pmode, rx_par)) perr_set = 1'b1;
                if (rx_end) rx_state_n = RX_STOP;
            end
            RX_STOP: if (rx_smp) begin
                rx_push    = 1'b1;
                ferr_set   = ~rx_s2;
                rx_state_n = RX_IDLE;
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: register table plus directed serial frame sequences
// for uart_core, with DIV = 3 giving 64 clk per bit.
module tb_uart_core;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       tx_bit, rx_bit, rx_drv, loop;
    logic [2:0] wb_addr;
    logic [7:0] wb_data_in, wb_data_out;
    logic       wb_we, wb_stb, wb_ack, irq;

    int n_cmp = 0;
    int n_bad = 0;

    assign rx_bit = loop ? tx_bit : rx_drv;

    always #5 clk = ~clk;

    uart_core dut (
        .clk(clk), .reset_n(reset_n), .tx_bit(tx_bit), .rx_bit(rx_bit),
        .wb_addr(wb_addr), .wb_data_in(wb_data_in),
        .wb_data_out(wb_data_out), .wb_we(wb_we), .wb_stb(wb_stb),
        .wb_ack(wb_ack), .irq(irq)
    );

    typedef struct {
        logic [2:0] a;
        logic       we;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic bus(input logic [2:0] a, input logic we,
                       input logic [7:0] d, output logic [7:0] q);
        int n;
        @(negedge clk);
        wb_addr = a; wb_we = we; wb_data_in = d; wb_stb = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!wb_ack && n < 8);
        if (!wb_ack) chk("bus_ack_timeout", 16'd0, 16'd1);
        q = wb_data_out;
        wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        logic [7:0] q;
        bus(a, 1'b1, d, q);
    endtask

    task automatic rd_chk(input string nm, input logic [2:0] a,
                          input logic [7:0] exp);
        logic [7:0] q;
        bus(a, 1'b0, 8'h00, q);
        chk(nm, {8'h00, q}, {8'h00, exp});
    endtask

    task automatic drive_frame(input logic [7:0] d, input int nb,
                               input int par, input logic flip,
                               input logic stop_val);
        logic p;
        p = 1'b0;
        rx_drv = 1'b0;
        repeat (64) @(posedge clk);
        for (int i = 0; i < nb; i++) begin
            rx_drv = d[i];
            p = p ^ d[i];
            repeat (64) @(posedge clk);
        end
        if (par != 0) begin
            rx_drv = ((par == 2) ? ~p : p) ^ flip;
            repeat (64) @(posedge clk);
        end
        rx_drv = stop_val;
        repeat (64) @(posedge clk);
        rx_drv = 1'b1;
        repeat (64) @(posedge clk);
    endtask

    // samples the middle of each bit cell after the start edge
    task automatic watch_tx(input int n, output logic [15:0] bits,
                            output int lat, output logic b63,
                            output logic b64);
        int t;
        lat = 0; bits = '1; b63 = 1'bx; b64 = 1'bx;
        while (tx_bit && lat < 400) begin
            @(posedge clk); #1; lat++;
        end
        t = 0;
        for (int k = 0; k < n; k++) begin
            while (t < 64 * k + 32) begin
                @(posedge clk); #1; t++;
                if (t == 63) b63 = tx_bit;
                if (t == 64) b64 = tx_bit;
            end
            bits[k] = tx_bit;
        end
    endtask

    initial begin
        logic [15:0] bits;
        logic [7:0]  q;
        logic        b63, b64;
        int          lat, acks, dbl, n;
        logic        prev;

        reset_n = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        wb_addr = '0; wb_data_in = '0; rx_drv = 1'b1; loop = 1'b0;

        tbl[0]  = '{ADDR_CTRL,   1'b0, 8'h00, 8'h63};
        tbl[1]  = '{ADDR_DIV_LO, 1'b0, 8'h00, 8'h4D};
        tbl[2]  = '{ADDR_DIV_HI, 1'b0, 8'h00, 8'h00};
        tbl[3]  = '{ADDR_STATUS, 1'b0, 8'h00, 8'h05};
        tbl[4]  = '{ADDR_TXDATA, 1'b0, 8'h00, 8'h00};
        tbl[5]  = '{ADDR_RXDATA, 1'b0, 8'h00, 8'h00};
        tbl[6]  = '{3'd6,        1'b0, 8'h00, 8'h00};
        tbl[7]  = '{3'd7,        1'b0, 8'h00, 8'h00};
        tbl[8]  = '{3'd6,        1'b1, 8'hFF, 8'h00};
        tbl[9]  = '{3'd6,        1'b0, 8'h00, 8'h00};
        tbl[10] = '{ADDR_DIV_LO, 1'b1, 8'h03, 8'h00};
        tbl[11] = '{ADDR_DIV_HI, 1'b1, 8'h00, 8'h00};
        tbl[12] = '{ADDR_DIV_LO, 1'b0, 8'h00, 8'h03};
        tbl[13] = '{ADDR_DIV_HI, 1'b0, 8'h00, 8'h00};
        tbl[14] = '{ADDR_CTRL,   1'b1, 8'h7A, 8'h00};
        tbl[15] = '{ADDR_CTRL,   1'b0, 8'h00, 8'h7A};
        tbl[16] = '{ADDR_CTRL,   1'b1, 8'h63, 8'h00};
        tbl[17] = '{ADDR_CTRL,   1'b0, 8'h00, 8'h63};
        tbl[18] = '{ADDR_STATUS, 1'b0, 8'h00, 8'h05};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_bit", {15'd0, tx_bit}, 16'd1);
        chk("rst_ack", {15'd0, wb_ack}, 16'd0);
        chk("rst_data_out", {8'd0, wb_data_out}, 16'd0);
        chk("rst_irq", {15'd0, irq}, 16'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 19; i++) begin
            bus(tbl[i].a, tbl[i].we, tbl[i].d, q);
            if (!tbl[i].we)
                chk($sformatf("reg_tbl[%0d]", i), {8'h00, q},
                    {8'h00, tbl[i].exp});
        end
        chk("idle_tx_bit", {15'd0, tx_bit}, 16'd1);

        // held strobe: single-cycle acks, never back to back
        @(negedge clk);
        wb_addr = ADDR_STATUS; wb_we = 1'b0; wb_stb = 1'b1;
        acks = 0; dbl = 0; prev = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (wb_ack) acks++;
            if (wb_ack && prev) dbl++;
            prev = wb_ack;
        end
        wb_stb = 1'b0;
        chk("ack_count", 16'(acks), 16'd3);
        chk("ack_double", 16'(dbl), 16'd0);
        repeat (2) @(posedge clk);

        // 8N1 loopback of A5
        loop = 1'b1;
        wr(ADDR_TXDATA, 8'hA5);
        watch_tx(10, bits, lat, b63, b64);
        chk("tx_a5_latency_ok", {15'd0, lat <= 6}, 16'd1);
        chk("tx_a5_frame", {6'd0, bits[9:0]}, {6'd0, 1'b1, 8'hA5, 1'b0});
        chk("tx_a5_start_63", {15'd0, b63}, 16'd0);
        chk("tx_a5_start_64", {15'd0, b64}, 16'd1);
        repeat (100) @(posedge clk);
        rd_chk("rx_a5", ADDR_RXDATA, 8'hA5);

        // 7 data bits, odd parity, two stop bits
        wr(ADDR_CTRL, 8'h7A);
        wr(ADDR_TXDATA, 8'h41);
        watch_tx(11, bits, lat, b63, b64);
        chk("tx_7o2_frame", {5'd0, bits[10:0]},
            {5'd0, 2'b11, 1'b1, 7'h41, 1'b0});
        repeat (100) @(posedge clk);
        rd_chk("rx_7o2", ADDR_RXDATA, 8'h41);
        rd_chk("status_7o2", ADDR_STATUS, 8'h05);
        loop = 1'b0;

        // 8E1: bad parity, then bad stop
        wr(ADDR_CTRL, 8'h67);
        drive_frame(8'h55, 8, 1, 1'b1, 1'b1);
        rd_chk("status_perr", ADDR_STATUS, 8'h11);
        rd_chk("rx_perr_byte", ADDR_RXDATA, 8'h55);
        drive_frame(8'h3C, 8, 1, 1'b0, 1'b0);
        rd_chk("status_ferr", ADDR_STATUS, 8'h31);
        rd_chk("rx_ferr_byte", ADDR_RXDATA, 8'h3C);
        wr(ADDR_STATUS, 8'h30);
        rd_chk("status_clr", ADDR_STATUS, 8'h05);

        wr(ADDR_CTRL, 8'hE3);
        #1 chk("irq_tx_empty", {15'd0, irq}, 16'd1);
        wr(ADDR_CTRL, 8'h63);
        #1 chk("irq_masked", {15'd0, irq}, 16'd0);

        // RX overrun with FIFO_DEPTH+1 frames
        for (int i = 0; i < 17; i++)
            drive_frame(8'h80 + 8'(i), 8, 0, 1'b0, 1'b1);
        rd_chk("status_overrun", ADDR_STATUS, 8'h49);
        n = 0;
        for (int i = 0; i < 16; i++) begin
            bus(ADDR_RXDATA, 1'b0, 8'h00, q);
            if (q !== 8'h80 + 8'(i)) n++;
        end
        chk("rx_fifo_order_errs", 16'(n), 16'd0);
        rd_chk("status_drained", ADDR_STATUS, 8'h45);
        wr(ADDR_STATUS, 8'hF0);

        // 8-clk start glitch
        rx_drv = 1'b0;
        repeat (8) @(posedge clk);
        rx_drv = 1'b1;
        repeat (200) @(posedge clk);
        rd_chk("status_glitch", ADDR_STATUS, 8'h05);

        // reset in the middle of a TX data bit
        drive_frame(8'h5A, 8, 0, 1'b0, 1'b1);
        wr(ADDR_TXDATA, 8'h00);
        wr(ADDR_TXDATA, 8'h11);
        wr(ADDR_TXDATA, 8'h22);
        n = 0;
        while (tx_bit && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("tx_reset_start_seen", {15'd0, tx_bit}, 16'd0);
        repeat (96) @(posedge clk);
        #1 chk("tx_mid_data_bit", {15'd0, tx_bit}, 16'd0);
        reset_n = 1'b0;
        #1 chk("tx_reset_async", {15'd0, tx_bit}, 16'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        rd_chk("status_after_reset", ADDR_STATUS, 8'h05);
        rd_chk("ctrl_after_reset", ADDR_CTRL, 8'h63);
        rd_chk("div_after_reset", ADDR_DIV_LO, 8'h4D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
